mips_cpu_muldiv_unit: RTL and testbench



---
 rtl/mips_cpu_muldiv_unit_if.sv | 40 ++++
 rtl/mips_cpu_muldiv_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mips_cpu_muldiv_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv_unit_if
//
// Purpose: groups the request/response signals between the CPU core and the
// HI/LO multiply-divide unit.
//
// Signals:
//   start  core -> unit  request strobe, sampled while the unit is not busy
//   op     core -> unit  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   a      core -> unit  Rs operand (dividend / multiplicand / MTHI/MTLO data)
//   b      core -> unit  Rt operand (divisor / multiplier)
//   busy   unit -> core  arithmetic operation in flight
//   done   unit -> core  one-cycle pulse after HI/LO take a mul/div result
//   hi     unit -> core  HI register
//   lo     unit -> core  LO register
//
// Modports: master = CPU core side, slave = multiply-divide unit side.
// ---------------------------------------------------------------------------
interface mips_cpu_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// mips_cpu_muldiv_unit
//
// Purpose: iterative HI/LO multiply-divide unit for the MIPS core. Owns the
// HI and LO registers and executes MULT/MULTU/DIV/DIVU one bit per cycle
// (shift-add multiply, restoring divide) followed by a single sign-fixup
// cycle. MTHI/MTLO write HI/LO directly while idle.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   reset       synchronous active-high reset, overrides clk_enable
//   clk_enable  when low, every register (including done) holds
//   bus         slave modport of mips_cpu_muldiv_unit_if
//                 (start/op/a/b in, busy/done/hi/lo out)
//
// Timing: start accepted at edge k -> busy after edges k..k+WIDTH,
// hi/lo updated and done=1 after edge k+WIDTH+1.
// ---------------------------------------------------------------------------
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    mips_cpu_muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIXUP
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    state_t             state;
    logic [CW-1:0]      count;

    // Multiply datapath: acc holds {partial product upper half, remaining
    // multiplier bits}; each step adds the multiplicand into the upper half
    // and shifts the whole thing right by one.
    logic [2*WIDTH-1:0] acc;
    // Multiplicand for multiply, divisor for divide.
    logic [WIDTH-1:0]   operand;

    // Divide datapath: quo starts as the dividend and is shifted out MSB
    // first while quotient bits are shifted in at the bottom.
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic               neg_q;
    logic               neg_r;
    logic               is_div;
    logic               div_zero;
    logic [WIDTH-1:0]   a_raw;

    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   q_fixed;
    logic [WIDTH-1:0]   r_fixed;

    // Operand magnitudes for signed ops. The most-negative value negates to
    // itself, which is exactly its magnitude when read as unsigned.
    always_comb begin
        signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One shift-add step and one restoring-divide step. The top bit of
    // div_diff is the borrow: clear means the divisor fits.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
    end

    // Sign correction applied in FIXUP: quotient truncates toward zero and
    // the remainder follows the dividend's sign.
    always_comb begin
        prod_fixed = neg_q ? -acc : acc;
        q_fixed    = neg_q ? -quo : quo;
        r_fixed    = neg_r ? -rem : rem;
    end

    // Main FSM. Reset aborts everything; with clk_enable low nothing moves,
    // so a stalled operation resumes exactly where it left off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                acc     <= {{WIDTH{1'b0}}, b_mag};
                                operand <= a_mag;
                                neg_q   <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r   <= 1'b0;
                                is_div  <= 1'b0;
                                count   <= '0;
                                busy_r  <= 1'b1;
                                state   <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                rem      <= '0;
                                quo      <= a_mag;
                                operand  <= b_mag;
                                neg_q    <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                neg_r    <= signed_op && bus.a[WIDTH-1];
                                is_div   <= 1'b1;
                                div_zero <= (bus.b == '0);
                                a_raw    <= bus.a;
                                count    <= '0;
                                busy_r   <= 1'b1;
                                state    <= DIV;
                            end
                            OP_MTHI: hi_r <= bus.a;
                            OP_MTLO: lo_r <= bus.a;
                            default: ;
                        endcase
                    end
                end

                MUL: begin
                    acc   <= {mul_sum, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end

                DIV: begin
                    if (!div_diff[WIDTH]) begin
                        rem <= div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_shift[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIXUP;
                    end
                end

                FIXUP: begin
                    // Divide by zero returns the untouched dividend in HI
                    // rather than the iterated remainder.
                    if (is_div) begin
                        if (div_zero) begin
                            hi_r <= a_raw;
                            lo_r <= '1;
                        end else begin
                            hi_r <= r_fixed;
                            lo_r <= q_fixed;
                        end
                    end else begin
                        hi_r <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fixed[WIDTH-1:0];
                    end
                    count  <= '0;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_muldiv_unit
//
// Purpose: directed self-checking bench for mips_cpu_muldiv_unit (WIDTH=32).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mips_cpu_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;

    int n_checks = 0;
    int n_fail   = 0;

    mips_cpu_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    mips_cpu_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    // One comparison: counted, and reported if it fails.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present a request on a falling edge, let one rising edge take it, then
    // scramble the operands so any late sampling would show up.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hA5A5_A5A5;
        bus.b     = 32'h5A5A_5A5A;
    endtask

    // Count falling-edge samples with busy high, starting at the current one.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        applyStimulus(op, a, b);
        @(negedge clk);
        waitDone(n);
        checkOutput({tag, "_latency"}, 64'(n), 64'(LAT));
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd1);
        checkOutput({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        checkOutput({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        @(negedge clk);
        checkOutput({tag, "_done_clear"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int done_seen;

        reset      = 1'b1;
        clk_enable = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.a      = '0;
        bus.b      = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;

        $display("[TB] arithmetic directed vectors");
        runOp("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("multu_fffex3", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        runOp("div_neg7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        runOp("divu_by_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        runOp("div_neg_by_zero", 3'd2, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);

        $display("[TB] MTHI / MTLO / reserved op");
        applyStimulus(3'd4, 32'h0000_1234, 32'd0);
        @(negedge clk);
        checkOutput("mthi_hi", 64'(bus.hi), 64'h1234);
        checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
        checkOutput("mthi_done", 64'(bus.done), 64'd0);
        applyStimulus(3'd5, 32'h0000_5678, 32'd0);
        @(negedge clk);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h5678);
        checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'h1234);
        checkOutput("mtlo_done", 64'(bus.done), 64'd0);
        applyStimulus(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("op6_hi", 64'(bus.hi), 64'h1234);
        checkOutput("op6_lo", 64'(bus.lo), 64'h5678);
        checkOutput("op6_busy", 64'(bus.busy), 64'd0);

        $display("[TB] clk_enable stall mid-multiply");
        applyStimulus(3'd0, 32'hFFFF_FFFB, 32'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        clk_enable = 1'b0;
        bus.start  = 1'b1;
        bus.op     = 3'd4;
        bus.a      = 32'h0000_DEAD;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_hi_held", 64'(bus.hi), 64'h1234);
        checkOutput("stall_busy", 64'(bus.busy), 64'd1);
        checkOutput("stall_done", 64'(bus.done), 64'd0);
        clk_enable = 1'b1;
        bus.start  = 1'b0;
        waitDone(n);
        checkOutput("stall_remaining", 64'(n), 64'(LAT - 10));
        checkOutput("stall_done_pulse", 64'(bus.done), 64'd1);
        checkOutput("stall_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        checkOutput("stall_lo", 64'(bus.lo), 64'hFFFF_FFDD);

        $display("[TB] reset mid-multiply");
        applyStimulus(3'd0, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_hi", 64'(bus.hi), 64'd0);
        checkOutput("abort_lo", 64'(bus.lo), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        checkOutput("abort_busy_later", 64'(bus.busy), 64'd0);

        $display("[TB] back-to-back issue in the done cycle");
        applyStimulus(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        waitDone(n);
        checkOutput("b2b_first_latency", 64'(n), 64'(LAT));
        checkOutput("b2b_first_done", 64'(bus.done), 64'd1);
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        @(negedge clk);
        checkOutput("b2b_done_cleared", 64'(bus.done), 64'd0);
        checkOutput("b2b_busy_set", 64'(bus.busy), 64'd1);
        checkOutput("b2b_hi_hold", 64'(bus.hi), 64'd2);
        checkOutput("b2b_lo_hold", 64'(bus.lo), 64'd14);
        repeat (20) @(negedge clk);
        checkOutput("b2b_hi_mid", 64'(bus.hi), 64'd2);
        checkOutput("b2b_lo_mid", 64'(bus.lo), 64'd14);
        waitDone(n);
        checkOutput("b2b_second_latency", 64'(n), 64'(LAT - 20));
        checkOutput("b2b_second_done", 64'(bus.done), 64'd1);
        checkOutput("b2b_second_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        checkOutput("b2b_second_lo", 64'(bus.lo), 64'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
